// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, size codes and FSM encodings for the MEM stage
package mem_access_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Unlisted f3 codes fall through to a word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      LS_B, LS_BU: return SZ_BYTE;
      LS_H, LS_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - single-outstanding req/ack data bus between MEM stage and memory
interface mem_access_if;
  import mem_access_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;
  logic            err;

  modport master (output req, we, addr, wdata, be, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata, err);

endinterface

// File: rtl/mem_access_align.sv
// rtl/mem_access_align.sv - combinational store lane/byte-enable formatting, misalign detect, load extract
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]      f3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] lane_wdata,
  output logic [3:0]      be,
  output logic            misaligned,
  input  logic [2:0]      load_f3,
  input  logic [1:0]      load_offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  size_e           st_size;
  size_e           ld_size;
  logic [XLEN-1:0] shifted;

  always_comb begin
    st_size    = f3_size(f3);
    lane_wdata = wdata;
    be         = 4'b1111;
    misaligned = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        lane_wdata = {4{wdata[7:0]}};
        be         = 4'b0001 << offset;
      end
      SZ_HALF: begin
        lane_wdata = {2{wdata[15:0]}};
        be         = 4'b0011 << {offset[1], 1'b0};
        misaligned = offset[0];
      end
      default: misaligned = |offset;
    endcase
  end

  // f3[2] marks the unsigned variants (BU/HU).
  always_comb begin
    ld_size   = f3_size(load_f3);
    shifted   = rdata >> {load_offset, 3'b000};
    load_data = shifted;
    case (ld_size)
      SZ_BYTE: load_data = {{24{shifted[7] & ~load_f3[2]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{shifted[15] & ~load_f3[2]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage load/store unit: issue FSM, bus registers and pipeline stall
module mem_access
  import mem_access_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_rd,
  input  logic            i_wr,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_stall,
  output logic            o_misaligned,
  output logic            o_fault,
  mem_access_if.master    bus
);

  logic [1:0]      state;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;
  logic [3:0]      lane_be;
  logic            mis;
  logic            access;

  mem_align u_align (
    .f3          (i_f3),
    .offset      (i_addr[1:0]),
    .wdata       (i_wdata),
    .lane_wdata  (lane_wdata),
    .be          (lane_be),
    .misaligned  (mis),
    .load_f3     (f3_q),
    .load_offset (off_q),
    .rdata       (bus.rdata),
    .load_data   (load_data)
  );

  assign access       = i_rd | i_wr;
  assign o_stall      = access & ~mis & (state != ST_DONE);
  assign o_misaligned = access & mis & (state == ST_IDLE);

  // DONE lets the pipeline advance past the instruction whose rd/wr is still asserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !mis) begin
            req_q   <= 1'b1;
            we_q    <= i_wr;
            addr_q  <= {i_addr[XLEN-1:2], 2'b00};
            wdata_q <= lane_wdata;
            be_q    <= lane_be;
            off_q   <= i_addr[1:0];
            f3_q    <= i_f3;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.ack) begin
            req_q   <= 1'b0;
            fault_q <= bus.err;
            if (!we_q) rdata_q <= bus.err ? '0 : load_data;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          fault_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.be    = be_q;
  assign o_rdata   = rdata_q;
  assign o_fault   = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with a responding bus slave
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        mis;
  logic        fault;

  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_rd         (rd),
    .i_wr         (wr),
    .i_f3         (f3),
    .o_rdata      (rdata),
    .o_stall      (stall),
    .o_misaligned (mis),
    .o_fault      (fault),
    .bus          (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  bus_t        req_q[$];
  rsp_t        rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f);
    if (f == LS_B || f == LS_BU) return 1;
    if (f == LS_H || f == LS_HU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] d);
    int          n;
    logic [31:0] mask;
    logic [31:0] v;
    n = size_bytes(f);
    v = d >> (8 * (a % 4));
    if (n == 4) return v;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if ((f == LS_B || f == LS_H) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Bus slave plus monitor: checks each request against the expected queue,
  // checks it stays stable through wait states, then checks the DONE result.
  initial begin
    bus_t cur;
    rsp_t r;
    bit   busy = 0;
    bit   done_pend = 0;
    bit   fault_next = 0;
    int   wcnt = 0;
    bus.ack = 1'b0;
    bus.err = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.ack = 1'b0;
      bus.err = 1'b0;
      if (!rst_n) begin
        busy = 0;
        done_pend = 0;
        fault_next = 0;
      end else begin
        if (fault_next) begin
          chk("fault_pulse", fault, 1'b0);
          fault_next = 0;
        end
        if (done_pend) begin
          if (rsp_q.size() == 0) chk("rsp_missing", 1, 0);
          else begin
            r = rsp_q.pop_front();
            chk("rdata", rdata, r.rdata);
            chk("fault", fault, r.fault);
          end
          chk("req_dropped", bus.req, 1'b0);
          done_pend = 0;
          fault_next = 1;
        end else if (bus.req) begin
          if (!busy) begin
            if (req_q.size() == 0) chk("unexpected_req", 1, 0);
            else begin
              cur = req_q.pop_front();
              busy = 1;
              wcnt = cur.waits;
            end
          end
          if (busy) begin
            chk("bus_we", bus.we, cur.we);
            chk("bus_addr", bus.addr, cur.addr);
            chk("bus_wdata", bus.wdata, cur.wdata);
            chk("bus_be", bus.be, cur.be);
            if (wcnt == 0) begin
              bus.ack = 1'b1;
              bus.rdata = cur.rdata;
              bus.err = cur.err;
              busy = 0;
              done_pend = 1;
            end else wcnt--;
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge where the next instruction may enter.
  task automatic run(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] bus_data, input bit e,
                     input int waits);
    int   n;
    int   cnt;
    bit   misal;
    bus_t b;
    rsp_t s;
    n = size_bytes(f);
    misal = (a % n) != 0;
    cnt = 0;
    if (!misal) begin
      b.we = w;
      b.addr = a & ~32'h3;
      b.be = 4'(((1 << n) - 1) << (a % 4));
      if (n == 1) b.wdata = {24'h0, wd[7:0]} * 32'h01010101;
      else if (n == 2) b.wdata = {16'h0, wd[15:0]} * 32'h00010001;
      else b.wdata = wd;
      b.rdata = bus_data;
      b.err = e;
      b.waits = waits;
      req_q.push_back(b);
      if (!w) model_rdata = e ? 32'h0 : load_model(f, a, bus_data);
      s.rdata = model_rdata;
      s.fault = e;
      rsp_q.push_back(s);
    end
    rd = r;
    wr = w;
    f3 = f;
    addr = a;
    wdata = wd;
    #1;
    if (misal) begin
      chk("misaligned", mis, 1'b1);
      chk("stall_misaligned", stall, 1'b0);
      @(negedge clk);
      #1;
      chk("misaligned_hold", mis, 1'b1);
      @(negedge clk);
    end else begin
      while (stall && cnt < 40) begin
        cnt++;
        @(negedge clk);
        #1;
      end
      chk("stall_cycles", cnt, waits + 2);
      @(negedge clk);
    end
  endtask

  task automatic bubble();
    rd = 1'b0;
    wr = 1'b0;
    #1;
    chk("idle_stall", stall, 1'b0);
    chk("idle_misaligned", mis, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1);
  end

  initial begin
    logic [2:0] codes [8];
    int         sel;
    logic [2:0] rf;
    codes = '{LS_B, LS_H, LS_W, LS_BU, LS_HU, 3'b011, 3'b110, 3'b111};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.req, 1'b0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_be", bus.be, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1, 0, LS_W,  32'h104, 32'h0, 32'hDEADBEEF, 0, 0);
    run(1, 0, LS_B,  32'h103, 32'h0, 32'h80123456, 0, 1);
    run(1, 0, LS_BU, 32'h103, 32'h0, 32'h80123456, 0, 0);
    run(0, 1, LS_H,  32'h202, 32'h0000ABCD, 32'h0, 0, 3);
    run(1, 0, LS_W,  32'h101, 32'h0, 32'h0, 0, 0);
    run(1, 0, LS_W,  32'h108, 32'h0, 32'h55, 1, 1);
    bubble();

    begin
      bus_t b;
      b.we = 1'b0;
      b.addr = 32'h400;
      b.wdata = 32'h0;
      b.be = 4'hF;
      b.rdata = 32'h1;
      b.err = 1'b0;
      b.waits = 10;
      req_q.push_back(b);
      rd = 1'b1;
      f3 = LS_W;
      addr = 32'h400;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      rd = 1'b0;
      #1;
      chk("arst_req", bus.req, 1'b0);
      chk("arst_we", bus.we, 1'b0);
      chk("arst_addr", bus.addr, 32'h0);
      chk("arst_wdata", bus.wdata, 32'h0);
      chk("arst_be", bus.be, 4'h0);
      chk("arst_rdata", rdata, 32'h0);
      chk("arst_fault", fault, 1'b0);
      model_rdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end

    run(0, 1, LS_B, 32'h301, 32'h12, 32'h0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      rf = codes[$urandom_range(0, 7)];
      run(sel != 1, sel == 1 || sel == 2, rf, $urandom, $urandom, $urandom,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bubble();
    end

    bubble();
    repeat (3) @(negedge clk);
    chk("req_queue_drained", req_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
